alu_result_collector: RTL and testbench

Downstream stage of the 16-bit ALU top. Each cycle it watches the four unit results and their valid flags, picks the single active unit, tags the result with its source, and buffers it in a small first-word-fall-through FIFO. A consumer drains the FIFO through a valid/ready handshake. Dropped results and multi-flag protocol errors are reported through status outputs.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_result_fifo.sv | 51 +++++
 rtl/alu_result_collector.sv | 109 ++++++++++
 tb/tb_alu_result_collector.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU result collector: source codes and entry sizing.
// Build with ALU_COLLECT_PARITY_EN defined to add a stored parity bit per entry.
package alu_pkg;

   localparam logic [1:0] SRC_ARITH = 2'b00;
   localparam logic [1:0] SRC_LOGIC = 2'b01;
   localparam logic [1:0] SRC_CMP   = 2'b10;
   localparam logic [1:0] SRC_SHIFT = 2'b11;

   localparam int ALU_WIDTH = 16;

   // Entry layout, MSB first: {src[1:0], data[WIDTH-1:0], carry[, parity]}
   function automatic int entry_width(input int width);
`ifdef ALU_COLLECT_PARITY_EN
      return width + 4;
`else
      return width + 3;
`endif
   endfunction

   localparam int ENTRY_WIDTH = entry_width(ALU_WIDTH);

endpackage

// File: rtl/alu_result_fifo.sv
// Generic first-word-fall-through FIFO: head entry is visible whenever count is non-zero.
// Pointers wrap naturally (DEPTH is a power of two); occupancy is tracked by a separate count.
module alu_result_fifo #(
   parameter int  WIDTH = 19,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Head is forced to zero when empty so outputs read as zero out of reset.
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_result_collector.sv
// Collects single-source ALU results into a FWFT FIFO with overflow and multi-flag status.
// Optional: define ALU_COLLECT_PARITY_EN to add RES_PARITY (even parity over carry and data).
module alu_result_collector
   import alu_pkg::*;
#(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             Clk,
   input  logic             RST,
   input  logic [WIDTH-1:0] Arith_OUT,
   input  logic [WIDTH-1:0] Logic_OUT,
   input  logic [WIDTH-1:0] CMP_OUT,
   input  logic [WIDTH-1:0] SHIFT_OUT,
   input  logic             Carry_OUT,
   input  logic             Arith_Flag,
   input  logic             Logic_Flag,
   input  logic             CMP_Flag,
   input  logic             SHIFT_Flag,
   input  logic             OVF_CLR,
   input  logic             RES_READY,
   output logic             RES_VALID,
   output logic [WIDTH-1:0] RES_DATA,
   output logic             RES_CARRY,
   output logic [1:0]       RES_SRC,
   output logic [CW-1:0]    FIFO_COUNT,
   output logic             OVERFLOW,
`ifdef ALU_COLLECT_PARITY_EN
   output logic             RES_PARITY,
`endif
   output logic             ERR_MULTI
);

   localparam int EW = entry_width(WIDTH);

   logic [3:0]       flags;
   logic             one_flag;
   logic             multi_flag;
   logic [1:0]       sel_src;
   logic [WIDTH-1:0] sel_data;
   logic             sel_carry;
   logic [EW-1:0]    wr_entry;
   logic [EW-1:0]    head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   assign flags      = {SHIFT_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
   assign one_flag   = (flags != 4'b0) && ((flags & (flags - 4'd1)) == 4'b0);
   assign multi_flag = (flags != 4'b0) && !one_flag;

   always_comb begin
      sel_src  = SRC_ARITH;
      sel_data = Arith_OUT;
      unique case (flags)
         4'b0010: begin sel_src = SRC_LOGIC; sel_data = Logic_OUT; end
         4'b0100: begin sel_src = SRC_CMP;   sel_data = CMP_OUT;   end
         4'b1000: begin sel_src = SRC_SHIFT; sel_data = SHIFT_OUT; end
         default: begin sel_src = SRC_ARITH; sel_data = Arith_OUT; end
      endcase
   end

   assign sel_carry = (sel_src == SRC_ARITH) ? Carry_OUT : 1'b0;

`ifdef ALU_COLLECT_PARITY_EN
   assign wr_entry = {sel_src, sel_data, sel_carry, ^{sel_carry, sel_data}};
`else
   assign wr_entry = {sel_src, sel_data, sel_carry};
`endif

   assign pop = RES_VALID && RES_READY;

   alu_result_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (Clk),
      .rst_n   (RST),
      .push    (one_flag),
      .pop     (pop),
      .wr_data (wr_entry),
      .rd_data (head),
      .count   (FIFO_COUNT),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign RES_VALID = !fifo_empty;
   assign RES_SRC   = head[EW-1 -: 2];
   assign RES_DATA  = head[EW-3 -: WIDTH];
   assign RES_CARRY = head[EW-3-WIDTH];
`ifdef ALU_COLLECT_PARITY_EN
   assign RES_PARITY = head[0];
`endif

   // Overflow set takes priority over a simultaneous clear.
   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         OVERFLOW  <= 1'b0;
         ERR_MULTI <= 1'b0;
      end else begin
         ERR_MULTI <= multi_flag;
         if (one_flag && fifo_full && !pop) OVERFLOW <= 1'b1;
         else if (OVF_CLR)                  OVERFLOW <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed self-checking bench for alu_result_collector (default DEPTH=4, WIDTH=16).
module tb_alu_result_collector;

   logic        Clk = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, SHIFT_OUT = '0;
   logic        Carry_OUT = 1'b0;
   logic        Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, SHIFT_Flag = 1'b0;
   logic        OVF_CLR = 1'b0;
   logic        RES_READY = 1'b0;
   logic        RES_VALID;
   logic [15:0] RES_DATA;
   logic        RES_CARRY;
   logic [1:0]  RES_SRC;
   logic [2:0]  FIFO_COUNT;
   logic        OVERFLOW;
   logic        ERR_MULTI;
`ifdef ALU_COLLECT_PARITY_EN
   logic        RES_PARITY;
`endif

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   alu_result_collector #(.WIDTH(16), .DEPTH(4)) dut (
      .Clk        (Clk),
      .RST        (RST),
      .Arith_OUT  (Arith_OUT),
      .Logic_OUT  (Logic_OUT),
      .CMP_OUT    (CMP_OUT),
      .SHIFT_OUT  (SHIFT_OUT),
      .Carry_OUT  (Carry_OUT),
      .Arith_Flag (Arith_Flag),
      .Logic_Flag (Logic_Flag),
      .CMP_Flag   (CMP_Flag),
      .SHIFT_Flag (SHIFT_Flag),
      .OVF_CLR    (OVF_CLR),
      .RES_READY  (RES_READY),
      .RES_VALID  (RES_VALID),
      .RES_DATA   (RES_DATA),
      .RES_CARRY  (RES_CARRY),
      .RES_SRC    (RES_SRC),
      .FIFO_COUNT (FIFO_COUNT),
      .OVERFLOW   (OVERFLOW),
`ifdef ALU_COLLECT_PARITY_EN
      .RES_PARITY (RES_PARITY),
`endif
      .ERR_MULTI  (ERR_MULTI)
   );

   // Advance one rising edge, then settle 1 time unit before sampling.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_flags();
      Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; SHIFT_Flag = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      repeat (2) step();
      checks++; if (RES_VALID !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%0b exp=0", RES_VALID); end
      checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", FIFO_COUNT); end
      checks++; if (OVERFLOW !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%0b exp=0", OVERFLOW); end
      checks++; if (ERR_MULTI !== 1'b0)  begin errors++; $display("FAIL reset_err got=%0b exp=0", ERR_MULTI); end
      checks++; if ({RES_SRC, RES_DATA, RES_CARRY} !== 19'd0) begin
         errors++; $display("FAIL reset_head got=%h/%h/%b exp=0/0000/0", RES_SRC, RES_DATA, RES_CARRY);
      end
      #3 RST = 1'b1;
      step();
      $display("reset: valid=%0b count=%0d ovf=%0b", RES_VALID, FIFO_COUNT, OVERFLOW);
   endtask

   task automatic test_logic_push();
      Logic_Flag = 1'b1; Logic_OUT = 16'h00F0; RES_READY = 1'b1;
      step();
      clear_flags();
      $display("logic push: valid=%0b data=%h src=%b carry=%b", RES_VALID, RES_DATA, RES_SRC, RES_CARRY);
      checks++; if (RES_VALID !== 1'b1)    begin errors++; $display("FAIL logic_valid got=%0b exp=1", RES_VALID); end
      checks++; if (RES_DATA !== 16'h00F0) begin errors++; $display("FAIL logic_data got=%h exp=00f0", RES_DATA); end
      checks++; if (RES_SRC !== 2'b01)     begin errors++; $display("FAIL logic_src got=%b exp=01", RES_SRC); end
      checks++; if (RES_CARRY !== 1'b0)    begin errors++; $display("FAIL logic_carry got=%b exp=0", RES_CARRY); end
`ifdef ALU_COLLECT_PARITY_EN
      checks++; if (RES_PARITY !== 1'b0)   begin errors++; $display("FAIL logic_parity got=%b exp=0", RES_PARITY); end
`endif
      step();
      checks++; if (RES_VALID !== 1'b0)    begin errors++; $display("FAIL logic_drained got=%0b exp=0", RES_VALID); end
      checks++; if (FIFO_COUNT !== 3'd0)   begin errors++; $display("FAIL logic_count got=%0d exp=0", FIFO_COUNT); end
   endtask

   task automatic test_carry();
      RES_READY = 1'b0;
      Arith_Flag = 1'b1; Arith_OUT = 16'h0000; Carry_OUT = 1'b1;
      step();
      clear_flags();
      $display("arith push: data=%h src=%b carry=%b", RES_DATA, RES_SRC, RES_CARRY);
      checks++; if (RES_CARRY !== 1'b1) begin errors++; $display("FAIL arith_carry got=%b exp=1", RES_CARRY); end
      checks++; if (RES_SRC !== 2'b00)  begin errors++; $display("FAIL arith_src got=%b exp=00", RES_SRC); end
`ifdef ALU_COLLECT_PARITY_EN
      checks++; if (RES_PARITY !== 1'b1) begin errors++; $display("FAIL arith_parity got=%b exp=1", RES_PARITY); end
`endif
      // Pop the arith entry while pushing a cmp entry with carry still high.
      RES_READY = 1'b1; CMP_Flag = 1'b1; CMP_OUT = 16'h1234;
      step();
      clear_flags();
      $display("cmp push: data=%h src=%b carry=%b count=%0d", RES_DATA, RES_SRC, RES_CARRY, FIFO_COUNT);
      checks++; if (RES_DATA !== 16'h1234) begin errors++; $display("FAIL cmp_data got=%h exp=1234", RES_DATA); end
      checks++; if (RES_SRC !== 2'b10)     begin errors++; $display("FAIL cmp_src got=%b exp=10", RES_SRC); end
      checks++; if (RES_CARRY !== 1'b0)    begin errors++; $display("FAIL cmp_carry got=%b exp=0", RES_CARRY); end
      checks++; if (FIFO_COUNT !== 3'd1)   begin errors++; $display("FAIL cmp_count got=%0d exp=1", FIFO_COUNT); end
      Carry_OUT = 1'b0;
      step();
   endtask

   task automatic test_overflow();
      RES_READY = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         SHIFT_Flag = 1'b1; SHIFT_OUT = 16'(i);
         step();
         $display("shift push %0d: count=%0d ovf=%0b", i, FIFO_COUNT, OVERFLOW);
         if (i == 4) begin
            checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b exp=0", OVERFLOW); end
         end
      end
      clear_flags();
      checks++; if (FIFO_COUNT !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", FIFO_COUNT); end
      checks++; if (OVERFLOW !== 1'b1)   begin errors++; $display("FAIL ovf_set got=%0b exp=1", OVERFLOW); end
      RES_READY = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         $display("drain %0d: valid=%0b data=%h src=%b", i, RES_VALID, RES_DATA, RES_SRC);
         checks++; if (RES_VALID !== 1'b1 || RES_DATA !== 16'(i) || RES_SRC !== 2'b11) begin
            errors++; $display("FAIL drain_%0d got=%0b/%h/%b exp=1/%h/11", i, RES_VALID, RES_DATA, RES_SRC, 16'(i));
         end
         step();
      end
      checks++; if (RES_VALID !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", RES_VALID); end
      checks++; if (OVERFLOW !== 1'b1)  begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", OVERFLOW); end
      OVF_CLR = 1'b1;
      step();
      OVF_CLR = 1'b0;
      checks++; if (OVERFLOW !== 1'b0)  begin errors++; $display("FAIL ovf_clr got=%0b exp=0", OVERFLOW); end
   endtask

   task automatic test_full_push_pop();
      logic [15:0] expq [4];
      expq[0] = 16'h0002; expq[1] = 16'h0003; expq[2] = 16'h0004; expq[3] = 16'hBEEF;
      RES_READY = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         SHIFT_Flag = 1'b1; SHIFT_OUT = 16'(i);
         step();
      end
      RES_READY = 1'b1; SHIFT_OUT = 16'hBEEF;
      step();
      clear_flags();
      $display("full push+pop: count=%0d ovf=%0b head=%h", FIFO_COUNT, OVERFLOW, RES_DATA);
      checks++; if (FIFO_COUNT !== 3'd4) begin errors++; $display("FAIL fpp_count got=%0d exp=4", FIFO_COUNT); end
      checks++; if (OVERFLOW !== 1'b0)   begin errors++; $display("FAIL fpp_ovf got=%0b exp=0", OVERFLOW); end
      for (int i = 0; i < 4; i++) begin
         $display("fpp drain %0d: data=%h", i, RES_DATA);
         checks++; if (RES_VALID !== 1'b1 || RES_DATA !== expq[i]) begin
            errors++; $display("FAIL fpp_drain_%0d got=%0b/%h exp=1/%h", i, RES_VALID, RES_DATA, expq[i]);
         end
         step();
      end
      checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL fpp_empty got=%0d exp=0", FIFO_COUNT); end
   endtask

   task automatic test_multi_flag();
      RES_READY = 1'b0;
      Logic_Flag = 1'b1; Logic_OUT = 16'h5555;
      step();
      clear_flags();
      Arith_Flag = 1'b1; CMP_Flag = 1'b1;
      step();
      clear_flags();
      $display("multi flag: err=%0b count=%0d", ERR_MULTI, FIFO_COUNT);
      checks++; if (ERR_MULTI !== 1'b1)  begin errors++; $display("FAIL multi_err got=%0b exp=1", ERR_MULTI); end
      checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL multi_count got=%0d exp=1", FIFO_COUNT); end
      step();
      checks++; if (ERR_MULTI !== 1'b0)  begin errors++; $display("FAIL multi_pulse got=%0b exp=0", ERR_MULTI); end
      checks++; if (RES_DATA !== 16'h5555) begin errors++; $display("FAIL multi_head got=%h exp=5555", RES_DATA); end
      RES_READY = 1'b1;
      step();
   endtask

   task automatic test_reset_mid_burst();
      RES_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Logic_Flag = 1'b1; Logic_OUT = 16'h1000 + 16'(i);
         step();
      end
      clear_flags();
      checks++; if (FIFO_COUNT !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", FIFO_COUNT); end
      RES_READY = 1'b1;
      RST = 1'b0;
      #1;
      $display("async reset: valid=%0b count=%0d", RES_VALID, FIFO_COUNT);
      checks++; if (RES_VALID !== 1'b0)  begin errors++; $display("FAIL mid_valid got=%0b exp=0", RES_VALID); end
      checks++; if (FIFO_COUNT !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", FIFO_COUNT); end
      step();
      #2 RST = 1'b1;
      Logic_Flag = 1'b1; Logic_OUT = 16'hA5A5;
      step();
      clear_flags();
      $display("post reset push: valid=%0b data=%h count=%0d", RES_VALID, RES_DATA, FIFO_COUNT);
      checks++; if (RES_VALID !== 1'b1 || RES_DATA !== 16'hA5A5) begin
         errors++; $display("FAIL post_head got=%0b/%h exp=1/a5a5", RES_VALID, RES_DATA);
      end
      checks++; if (FIFO_COUNT !== 3'd1) begin errors++; $display("FAIL post_count got=%0d exp=1", FIFO_COUNT); end
      step();
      checks++; if (RES_VALID !== 1'b0)  begin errors++; $display("FAIL post_only got=%0b exp=0", RES_VALID); end
   endtask

   initial begin
      test_reset();
      test_logic_push();
      test_carry();
      test_overflow();
      test_full_push_pop();
      test_multi_flag();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
